// File: rtl/hilo_muldiv_if.sv
// Handshake/result bundle between the control unit (master) and the Hi/Lo
// multiply/divide unit (slave).
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, hi_wr, lo_wr, wdata,
        input  hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, a, b, hi_wr, lo_wr, wdata,
        output hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the Hi/Lo pair.
// Define HILO_DIV_EN to build the divide datapath; otherwise DIV/DIVU are no-ops.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic          clk,
    input logic          reset,
    hilo_muldiv_if.slave bus
);

`ifdef HILO_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic             r_imm_pend;
    logic             r_imm_dbz;

    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic             w_launch;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    // op[0]=0 selects the signed variants; magnitudes feed the unsigned core
    assign w_is_div = bus.op[1];
    assign w_a_neg  = ~bus.op[0] & bus.a[WIDTH-1];
    assign w_b_neg  = ~bus.op[0] & bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag  = w_b_neg ? -bus.b : bus.b;
    assign w_b_zero = (bus.b == '0);
    assign w_launch = ~w_is_div | (DIV_EN & ~w_b_zero);

    assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

`ifdef HILO_DIV_EN
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_unused_div;

    // Partial remainder is always below the divisor, so WIDTH+1 bits suffice
    assign w_div_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_diff   = {1'b0, w_div_shift} - {2'b00, r_mcand};
    assign w_div_ok     = ~w_div_diff[WIDTH+1];
    assign w_quo_fix    = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix    = r_neg_r ? -r_acc_hi : r_acc_hi;
    assign w_unused_div = &{1'b0, w_div_diff[WIDTH]};

    assign w_step_hi = r_is_div ? (w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0])
                                : w_mul_sum[WIDTH:1];
    assign w_step_lo = r_is_div ? {r_acc_lo[WIDTH-2:0], w_div_ok}
                                : {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
    assign w_res_hi  = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo  = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];
`else
    logic w_unused_div;

    assign w_unused_div = &{1'b0, r_is_div, r_neg_r};
    assign w_step_hi    = w_mul_sum[WIDTH:1];
    assign w_step_lo    = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
    assign w_res_hi     = w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo     = w_prod_fix[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_mcand    <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_imm_pend <= 1'b0;
            r_imm_dbz  <= 1'b0;
        end else begin
            // Immediate completions (divide by zero, disabled divide) surface one edge later
            r_done     <= r_imm_pend;
            r_dbz      <= r_imm_pend & r_imm_dbz;
            r_imm_pend <= 1'b0;
            r_imm_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_launch) begin
                            r_state  <= S_CALC;
                            r_busy   <= 1'b1;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_is_div <= w_is_div;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_mcand  <= w_b_mag;
                            r_acc_hi <= '0;
                            r_acc_lo <= w_a_mag;
                        end else begin
                            r_imm_pend <= 1'b1;
                            r_imm_dbz  <= DIV_EN;
                        end
                    end else begin
                        if (bus.hi_wr) r_hi <= bus.wdata;
                        if (bus.lo_wr) r_lo <= bus.wdata;
                    end
                end
                S_CALC: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;

endmodule
